// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared widths, unit encoding and forwarding tap type for the SPU pipes
package spu_pkg;

  localparam int REG_ADDR_W = 7;
  localparam int NUM_REGS   = 128;
  localparam int WIDTH      = 128;
  localparam int OP_W       = 11;
  localparam int IMM_W      = 18;
  localparam int FORMAT_W   = 3;
  localparam int FWD_TAPS   = 7;

  typedef enum logic [1:0] {
    UNIT_FP   = 2'd0,
    UNIT_FX2  = 2'd1,
    UNIT_BYTE = 2'd2,
    UNIT_FX1  = 2'd3
  } unit_e;

  typedef struct packed {
    logic [WIDTH-1:0]      data;
    logic [REG_ADDR_W-1:0] addr;
    logic                  wr;
  } fwd_tap_t;

endpackage

// File: rtl/reg_fwd_stage_operand_resolve.sv
// rtl/reg_fwd_stage_operand_resolve.sv - priority mux choosing one source operand
// from forwarding taps, same-cycle writeback or the register array.
module operand_resolve
  import spu_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  fwd_tap_t              ev_tap [1:FWD_TAPS],
  input  fwd_tap_t              od_tap [1:FWD_TAPS],
  input  logic                  ev_wb_wr,
  input  logic [REG_ADDR_W-1:0] ev_wb_addr,
  input  logic [WIDTH-1:0]      ev_wb_data,
  input  logic                  od_wb_wr,
  input  logic [REG_ADDR_W-1:0] od_wb_addr,
  input  logic [WIDTH-1:0]      od_wb_data,
  input  logic [WIDTH-1:0]      arr_data,
  output logic [WIDTH-1:0]      result
);

  // Lowest priority assigned first; later assignments override, so the walk runs
  // oldest tap to youngest and odd after even at every level.
  always_comb begin
    result = arr_data;
    if (ev_wb_wr && ev_wb_addr == src) result = ev_wb_data;
    if (od_wb_wr && od_wb_addr == src) result = od_wb_data;
    for (int k = FWD_TAPS; k >= 1; k--) begin
      if (ev_tap[k].wr && ev_tap[k].addr == src) result = ev_tap[k].data;
      if (od_tap[k].wr && od_tap[k].addr == src) result = od_tap[k].data;
    end
  end

endmodule

// File: rtl/reg_fwd_stage.sv
// rtl/reg_fwd_stage.sv - 128x128b register file with forwarding; registers resolved
// operands and decode fields into the even/odd execute pipes.
module reg_fwd_stage
  import spu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [0:OP_W-1]       ev_op,
  input  logic [0:OP_W-1]       od_op,
  input  logic [FORMAT_W-1:0]   ev_format,
  input  logic [FORMAT_W-1:0]   od_format,
  input  unit_e                 ev_unit,
  input  unit_e                 od_unit,
  input  logic [0:IMM_W-1]      ev_imm,
  input  logic [0:IMM_W-1]      od_imm,
  input  logic [REG_ADDR_W-1:0] ev_rt_addr,
  input  logic [REG_ADDR_W-1:0] od_rt_addr,
  input  logic                  ev_reg_write,
  input  logic                  od_reg_write,
  input  logic [REG_ADDR_W-1:0] ev_ra_addr,
  input  logic [REG_ADDR_W-1:0] ev_rb_addr,
  input  logic [REG_ADDR_W-1:0] ev_rc_addr,
  input  logic [REG_ADDR_W-1:0] od_ra_addr,
  input  logic [REG_ADDR_W-1:0] od_rb_addr,
  input  logic [REG_ADDR_W-1:0] od_rc_addr,
  input  logic [WIDTH-1:0]      ev_wb_data,
  input  logic [REG_ADDR_W-1:0] ev_wb_addr,
  input  logic                  ev_wb_wr,
  input  logic [WIDTH-1:0]      od_wb_data,
  input  logic [REG_ADDR_W-1:0] od_wb_addr,
  input  logic                  od_wb_wr,
  input  logic [WIDTH-1:0]      ev_fw_data [1:FWD_TAPS],
  input  logic [REG_ADDR_W-1:0] ev_fw_addr [1:FWD_TAPS],
  input  logic                  ev_fw_wr   [1:FWD_TAPS],
  input  logic [WIDTH-1:0]      od_fw_data [1:FWD_TAPS],
  input  logic [REG_ADDR_W-1:0] od_fw_addr [1:FWD_TAPS],
  input  logic                  od_fw_wr   [1:FWD_TAPS],
  output logic [WIDTH-1:0]      ev_ra,
  output logic [WIDTH-1:0]      ev_rb,
  output logic [WIDTH-1:0]      ev_rc,
  output logic [WIDTH-1:0]      od_ra,
  output logic [WIDTH-1:0]      od_rb,
  output logic [WIDTH-1:0]      od_rc,
  output logic [0:OP_W-1]       ev_op_q,
  output logic [0:OP_W-1]       od_op_q,
  output logic [FORMAT_W-1:0]   ev_format_q,
  output logic [FORMAT_W-1:0]   od_format_q,
  output unit_e                 ev_unit_q,
  output unit_e                 od_unit_q,
  output logic [0:IMM_W-1]      ev_imm_q,
  output logic [0:IMM_W-1]      od_imm_q,
  output logic [REG_ADDR_W-1:0] ev_rt_addr_q,
  output logic [REG_ADDR_W-1:0] od_rt_addr_q,
  output logic                  ev_reg_write_q,
  output logic                  od_reg_write_q
);

  logic [WIDTH-1:0]      rf [NUM_REGS];
  fwd_tap_t              ev_taps [1:FWD_TAPS];
  fwd_tap_t              od_taps [1:FWD_TAPS];
  logic [REG_ADDR_W-1:0] src [6];
  logic [WIDTH-1:0]      res [6];

  always_comb begin
    for (int k = 1; k <= FWD_TAPS; k++) begin
      ev_taps[k] = '{data: ev_fw_data[k], addr: ev_fw_addr[k], wr: ev_fw_wr[k]};
      od_taps[k] = '{data: od_fw_data[k], addr: od_fw_addr[k], wr: od_fw_wr[k]};
    end
  end

  assign src = '{ev_ra_addr, ev_rb_addr, ev_rc_addr, od_ra_addr, od_rb_addr, od_rc_addr};

  for (genvar i = 0; i < 6; i++) begin : g_opnd
    operand_resolve u_resolve (
      .src        (src[i]),
      .ev_tap     (ev_taps),
      .od_tap     (od_taps),
      .ev_wb_wr   (ev_wb_wr),
      .ev_wb_addr (ev_wb_addr),
      .ev_wb_data (ev_wb_data),
      .od_wb_wr   (od_wb_wr),
      .od_wb_addr (od_wb_addr),
      .od_wb_data (od_wb_data),
      .arr_data   (rf[src[i]]),
      .result     (res[i])
    );
  end

  // Writeback ignores stall; odd write lands last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      if (ev_wb_wr) rf[ev_wb_addr] <= ev_wb_data;
      if (od_wb_wr) rf[od_wb_addr] <= od_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_ra <= '0; ev_rb <= '0; ev_rc <= '0;
      od_ra <= '0; od_rb <= '0; od_rc <= '0;
      ev_op_q <= '0;         od_op_q <= '0;
      ev_format_q <= '0;     od_format_q <= '0;
      ev_unit_q <= UNIT_FP;  od_unit_q <= UNIT_FP;
      ev_imm_q <= '0;        od_imm_q <= '0;
      ev_rt_addr_q <= '0;    od_rt_addr_q <= '0;
      ev_reg_write_q <= 1'b0; od_reg_write_q <= 1'b0;
    end else if (!stall) begin
      ev_ra <= res[0]; ev_rb <= res[1]; ev_rc <= res[2];
      od_ra <= res[3]; od_rb <= res[4]; od_rc <= res[5];
      ev_op_q <= ev_op;               od_op_q <= od_op;
      ev_format_q <= ev_format;       od_format_q <= od_format;
      ev_unit_q <= ev_unit;           od_unit_q <= od_unit;
      ev_imm_q <= ev_imm;             od_imm_q <= od_imm;
      ev_rt_addr_q <= ev_rt_addr;     od_rt_addr_q <= od_rt_addr;
      ev_reg_write_q <= ev_reg_write; od_reg_write_q <= od_reg_write;
    end
  end

endmodule

// File: tb/tb_reg_fwd_stage.sv
// tb/tb_reg_fwd_stage.sv - directed stimulus with a cycle-tagged expectation queue
// drained by an independent negedge monitor.
module tb_reg_fwd_stage;
  import spu_pkg::*;

  logic clk = 1'b0;
  logic reset, stall;
  logic [0:OP_W-1] ev_op, od_op;
  logic [FORMAT_W-1:0] ev_format, od_format;
  unit_e ev_unit, od_unit;
  logic [0:IMM_W-1] ev_imm, od_imm;
  logic [REG_ADDR_W-1:0] ev_rt_addr, od_rt_addr;
  logic ev_reg_write, od_reg_write;
  logic [REG_ADDR_W-1:0] ev_ra_addr, ev_rb_addr, ev_rc_addr, od_ra_addr, od_rb_addr, od_rc_addr;
  logic [WIDTH-1:0] ev_wb_data, od_wb_data;
  logic [REG_ADDR_W-1:0] ev_wb_addr, od_wb_addr;
  logic ev_wb_wr, od_wb_wr;
  logic [WIDTH-1:0] ev_fw_data [1:FWD_TAPS];
  logic [REG_ADDR_W-1:0] ev_fw_addr [1:FWD_TAPS];
  logic ev_fw_wr [1:FWD_TAPS];
  logic [WIDTH-1:0] od_fw_data [1:FWD_TAPS];
  logic [REG_ADDR_W-1:0] od_fw_addr [1:FWD_TAPS];
  logic od_fw_wr [1:FWD_TAPS];
  logic [WIDTH-1:0] ev_ra, ev_rb, ev_rc, od_ra, od_rb, od_rc;
  logic [0:OP_W-1] ev_op_q, od_op_q;
  logic [FORMAT_W-1:0] ev_format_q, od_format_q;
  unit_e ev_unit_q, od_unit_q;
  logic [0:IMM_W-1] ev_imm_q, od_imm_q;
  logic [REG_ADDR_W-1:0] ev_rt_addr_q, od_rt_addr_q;
  logic ev_reg_write_q, od_reg_write_q;

  reg_fwd_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .ev_op(ev_op), .od_op(od_op), .ev_format(ev_format), .od_format(od_format),
    .ev_unit(ev_unit), .od_unit(od_unit), .ev_imm(ev_imm), .od_imm(od_imm),
    .ev_rt_addr(ev_rt_addr), .od_rt_addr(od_rt_addr),
    .ev_reg_write(ev_reg_write), .od_reg_write(od_reg_write),
    .ev_ra_addr(ev_ra_addr), .ev_rb_addr(ev_rb_addr), .ev_rc_addr(ev_rc_addr),
    .od_ra_addr(od_ra_addr), .od_rb_addr(od_rb_addr), .od_rc_addr(od_rc_addr),
    .ev_wb_data(ev_wb_data), .ev_wb_addr(ev_wb_addr), .ev_wb_wr(ev_wb_wr),
    .od_wb_data(od_wb_data), .od_wb_addr(od_wb_addr), .od_wb_wr(od_wb_wr),
    .ev_fw_data(ev_fw_data), .ev_fw_addr(ev_fw_addr), .ev_fw_wr(ev_fw_wr),
    .od_fw_data(od_fw_data), .od_fw_addr(od_fw_addr), .od_fw_wr(od_fw_wr),
    .ev_ra(ev_ra), .ev_rb(ev_rb), .ev_rc(ev_rc), .od_ra(od_ra), .od_rb(od_rb), .od_rc(od_rc),
    .ev_op_q(ev_op_q), .od_op_q(od_op_q), .ev_format_q(ev_format_q), .od_format_q(od_format_q),
    .ev_unit_q(ev_unit_q), .od_unit_q(od_unit_q), .ev_imm_q(ev_imm_q), .od_imm_q(od_imm_q),
    .ev_rt_addr_q(ev_rt_addr_q), .od_rt_addr_q(od_rt_addr_q),
    .ev_reg_write_q(ev_reg_write_q), .od_reg_write_q(od_reg_write_q)
  );

  always #5 clk = ~clk;

  typedef enum int {K_EV_RA, K_EV_RB, K_EV_RC, K_OD_RA, K_OD_RB, K_OD_RC,
                    K_EV_RWQ, K_OD_RWQ, K_EV_OPQ, K_OD_IMMQ} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    logic [127:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] sel(kind_e k);
    case (k)
      K_EV_RA:   return ev_ra;
      K_EV_RB:   return ev_rb;
      K_EV_RC:   return ev_rc;
      K_OD_RA:   return od_ra;
      K_OD_RB:   return od_rb;
      K_OD_RC:   return od_rc;
      K_EV_RWQ:  return {127'b0, ev_reg_write_q};
      K_OD_RWQ:  return {127'b0, od_reg_write_q};
      K_EV_OPQ:  return {117'b0, ev_op_q};
      default:   return {110'b0, od_imm_q};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      logic [127:0] act;
      e = sb.pop_front();
      act = sel(e.kind);
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s: check overdue (due cycle %0d, now %0d)", e.name, e.due, cyc);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(kind_e k, logic [127:0] v, string n);
    exp_t e;
    e.due = cyc + 1; e.kind = k; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    reset = 0; stall = 0;
    ev_op = '0; od_op = '0; ev_format = '0; od_format = '0;
    ev_unit = UNIT_FX1; od_unit = UNIT_BYTE; ev_imm = '0; od_imm = '0;
    ev_rt_addr = 7'd1; od_rt_addr = 7'd2; ev_reg_write = 0; od_reg_write = 0;
    ev_ra_addr = '0; ev_rb_addr = '0; ev_rc_addr = '0;
    od_ra_addr = '0; od_rb_addr = '0; od_rc_addr = '0;
    ev_wb_data = '0; ev_wb_addr = '0; ev_wb_wr = 0;
    od_wb_data = '0; od_wb_addr = '0; od_wb_wr = 0;
    for (int k = 1; k <= FWD_TAPS; k++) begin
      ev_fw_data[k] = '0; ev_fw_addr[k] = '0; ev_fw_wr[k] = 0;
      od_fw_data[k] = '0; od_fw_addr[k] = '0; od_fw_wr[k] = 0;
    end
  endtask

  localparam logic [127:0] VA = {4{32'hAAAA_AAAA}};

  initial begin
    clear();
    reset = 1;
    expect_v(K_EV_RA, 0, "rst_ev_ra"); expect_v(K_OD_RC, 0, "rst_od_rc");
    expect_v(K_EV_RWQ, 0, "rst_ev_rwq"); expect_v(K_OD_RWQ, 0, "rst_od_rwq");
    tick();

    // writeback then read through the array
    clear(); ev_wb_wr = 1; ev_wb_addr = 5; ev_wb_data = VA; tick();
    clear(); ev_ra_addr = 5; ev_reg_write = 1; ev_op = 11'h5A3;
    expect_v(K_EV_RA, VA, "t1_ev_ra"); expect_v(K_EV_RWQ, 1, "t1_ev_rwq");
    expect_v(K_EV_OPQ, 128'h5A3, "t1_ev_opq"); tick();

    // same-cycle WB bypass
    clear(); od_wb_wr = 1; od_wb_addr = 9; od_wb_data = 128'h1234;
    od_rb_addr = 9; ev_rb_addr = 9; od_imm = 18'h2ABCD;
    expect_v(K_OD_RB, 128'h1234, "t2_od_rb"); expect_v(K_EV_RB, 128'h1234, "t2_ev_rb");
    expect_v(K_OD_IMMQ, 128'h2ABCD, "t2_od_immq"); tick();

    // tap priority: tap1 > tap4 > wb > array
    clear(); ev_fw_wr[1] = 1; ev_fw_addr[1] = 5; ev_fw_data[1] = 128'hB;
    ev_fw_wr[4] = 1; ev_fw_addr[4] = 5; ev_fw_data[4] = 128'hC;
    ev_wb_wr = 1; ev_wb_addr = 5; ev_wb_data = 128'hD; ev_ra_addr = 5;
    expect_v(K_EV_RA, 128'hB, "t3_tap1"); tick();
    clear(); ev_fw_wr[4] = 1; ev_fw_addr[4] = 5; ev_fw_data[4] = 128'hC;
    ev_wb_wr = 1; ev_wb_addr = 5; ev_wb_data = 128'hD; ev_ra_addr = 5;
    expect_v(K_EV_RA, 128'hC, "t3_tap4"); tick();
    clear(); ev_fw_wr[2] = 1; ev_fw_addr[2] = 7'h45; ev_fw_data[2] = 128'h77;
    ev_fw_wr[7] = 1; ev_fw_addr[7] = 5; ev_fw_data[7] = 128'hE;
    ev_ra_addr = 5; od_ra_addr = 5;
    expect_v(K_EV_RA, 128'hE, "t3_tap7_fulladdr"); expect_v(K_OD_RA, 128'hE, "t3_od_sees_evtap"); tick();
    clear(); ev_ra_addr = 5; expect_v(K_EV_RA, 128'hD, "t3_array"); tick();

    // odd wins ties
    clear(); ev_wb_wr = 1; ev_wb_addr = 7; ev_wb_data = 128'h1;
    od_wb_wr = 1; od_wb_addr = 7; od_wb_data = 128'h2; tick();
    clear(); od_ra_addr = 7; expect_v(K_OD_RA, 128'h2, "t4_wb_tie"); tick();
    clear(); ev_fw_wr[3] = 1; ev_fw_addr[3] = 7; ev_fw_data[3] = 128'h33;
    od_fw_wr[3] = 1; od_fw_addr[3] = 7; od_fw_data[3] = 128'h44;
    od_fw_wr[5] = 1; od_fw_addr[5] = 7; od_fw_data[5] = 128'h55;
    ev_rc_addr = 7; od_rc_addr = 7;
    expect_v(K_EV_RC, 128'h44, "t4_tap_tie_ev"); expect_v(K_OD_RC, 128'h44, "t4_tap_tie_od"); tick();

    // stall holds outputs while WB still writes
    clear(); ev_ra_addr = 5; ev_reg_write = 1;
    expect_v(K_EV_RA, 128'hD, "t5_pre"); tick();
    for (int i = 0; i < 3; i++) begin
      clear(); stall = 1; ev_wb_wr = 1; ev_wb_addr = 3; ev_wb_data = 128'h5; ev_ra_addr = 3;
      expect_v(K_EV_RA, 128'hD, "t5_hold_ra"); expect_v(K_EV_RWQ, 0, "t5_hold_rwq_flip");
      sb[$].val = 1;
      tick();
    end
    clear(); ev_ra_addr = 3; expect_v(K_EV_RA, 128'h5, "t5_release"); tick();

    // reset mid-stream, with stall and a WB write pending
    clear(); ev_wb_wr = 1; ev_wb_addr = 2; ev_wb_data = 128'hF; tick();
    clear(); ev_ra_addr = 2; ev_reg_write = 1; od_reg_write = 1;
    expect_v(K_EV_RA, 128'hF, "t6_pre"); expect_v(K_OD_RWQ, 1, "t6_pre_rwq"); tick();
    clear(); reset = 1; stall = 1; ev_wb_wr = 1; ev_wb_addr = 2; ev_wb_data = 128'h99;
    ev_ra_addr = 2; ev_reg_write = 1; od_reg_write = 1; ev_op = 11'h7FF;
    expect_v(K_EV_RA, 0, "t6_rst_ra"); expect_v(K_EV_RWQ, 0, "t6_rst_ev_rwq");
    expect_v(K_OD_RWQ, 0, "t6_rst_od_rwq"); expect_v(K_EV_OPQ, 0, "t6_rst_opq"); tick();
    clear(); ev_ra_addr = 2; od_ra_addr = 5; od_rb_addr = 7;
    expect_v(K_EV_RA, 0, "t6_r2_cleared"); expect_v(K_OD_RA, 0, "t6_r5_cleared");
    expect_v(K_OD_RB, 0, "t6_r7_cleared"); tick();

    clear(); tick(); tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
